// File: rtl/add_round_key_seq.sv
// AES AddRoundKey: XORs a BLOCK_W state with a stored round key, LANE_W bits per cycle.
// Latency: out_valid rises BEATS edges after the acceptance edge.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module add_round_key_seq #(
    parameter int BLOCK_W  = 128,
    parameter int LANE_W   = 32,
    parameter int NUM_KEYS = 11,
    parameter int KA_W     = $clog2(NUM_KEYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_we,
    input  logic [KA_W-1:0]    key_addr,
    input  logic [BLOCK_W-1:0] key_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [KA_W-1:0]    in_round,
    input  logic               in_bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_err
);
    localparam int BEATS = BLOCK_W / LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KA_W:0]    KEY_LIMIT = (KA_W + 1)'(NUM_KEYS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] data_q;
    logic [BLOCK_W-1:0] key_q;
    logic               err_q;
    logic [BLOCK_W-1:0] key_mem [NUM_KEYS];
    logic [BLOCK_W-1:0] sel_key;
    logic               round_oor;
    logic               accept;
    logic               key_wr_ok;

    assign round_oor = ({1'b0, in_round} >= KEY_LIMIT);
    assign key_wr_ok = key_we && ({1'b0, key_addr} < KEY_LIMIT);
    assign in_ready  = (state == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;

    assign out_valid = (state == S_DONE);
    assign out_data  = data_q;
    assign out_err   = err_q;

    // Key is copied at acceptance, so later slot writes never touch an in-flight block.
    always_comb begin
        sel_key = '0;
        if (!in_bypass && !round_oor) begin
            sel_key = key_mem[in_round];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
        end else if (key_wr_ok) begin
            key_mem[key_addr] <= key_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            data_q <= '0;
            key_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        data_q <= in_data;
                        key_q  <= sel_key;
                        err_q  <= round_oor && !in_bypass;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < BEATS; n++) begin
                        if (cnt == CNT_W'(n)) begin
                            data_q[n*LANE_W +: LANE_W] <= data_q[n*LANE_W +: LANE_W]
                                                        ^ key_q[n*LANE_W +: LANE_W];
                        end
                    end
                    if (cnt == LAST_BEAT) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_round_key_seq.sv
// Scoreboard bench for add_round_key_seq: 32-bit-lane instance (a_*) and 128-bit-lane instance (b_*).
module tb_add_round_key_seq;
    localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K3   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] D    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E0   = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] E3   = 128'h0f1f2f3f4f5f6f7f8f9fafbfcfdfefff;
    localparam logic [127:0] ND   = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] D2   = 128'hdeadbeef0123456789abcdeffedcba98;

    typedef struct packed {
        logic [127:0] d;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         a_key_we, a_in_valid, a_in_ready, a_in_bypass, a_out_valid, a_out_ready, a_out_err;
    logic [3:0]   a_key_addr, a_in_round;
    logic [127:0] a_key_data, a_in_data, a_out_data;
    logic         b_key_we, b_in_valid, b_in_ready, b_in_bypass, b_out_valid, b_out_ready, b_out_err;
    logic [3:0]   b_key_addr, b_in_round;
    logic [127:0] b_key_data, b_in_data, b_out_data;

    add_round_key_seq #(.BLOCK_W(128), .LANE_W(32), .NUM_KEYS(11), .KA_W(4)) dut_a (
        .clk(clk), .rst(rst), .key_we(a_key_we), .key_addr(a_key_addr), .key_data(a_key_data),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_round(a_in_round),
        .in_bypass(a_in_bypass), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_err(a_out_err)
    );

    add_round_key_seq #(.BLOCK_W(128), .LANE_W(128), .NUM_KEYS(11), .KA_W(4)) dut_b (
        .clk(clk), .rst(rst), .key_we(b_key_we), .key_addr(b_key_addr), .key_data(b_key_data),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_round(b_in_round),
        .in_bypass(b_in_bypass), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_err(b_out_err)
    );

    int total = 0;
    int bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitors: a handshake happens at the posedge following a negedge with valid&ready.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_out: got %h want none", a_out_data);
            end else begin
                ea = qa.pop_front();
                if (a_out_data !== ea.d || a_out_err !== ea.e) begin
                    bad++;
                    $display("FAIL a_result: got %h err %b want %h err %b", a_out_data, a_out_err, ea.d, ea.e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_out: got %h want none", b_out_data);
            end else begin
                eb = qb.pop_front();
                if (b_out_data !== eb.d || b_out_err !== eb.e) begin
                    bad++;
                    $display("FAIL b_result: got %h err %b want %h err %b", b_out_data, b_out_err, eb.d, eb.e);
                end
            end
        end
    end

    task automatic a_wr(input logic [3:0] addr, input logic [127:0] dat);
        a_key_we = 1'b1; a_key_addr = addr; a_key_data = dat;
        @(posedge clk); #1;
        a_key_we = 1'b0;
    endtask

    task automatic b_wr(input logic [3:0] addr, input logic [127:0] dat);
        b_key_we = 1'b1; b_key_addr = addr; b_key_data = dat;
        @(posedge clk); #1;
        b_key_we = 1'b0;
    endtask

    task automatic a_send(input logic [127:0] dat, input logic [3:0] rnd, input logic byp,
                          input logic [127:0] exp_d, input logic exp_e, input bit push);
        int w = 0;
        a_in_valid = 1'b1; a_in_data = dat; a_in_round = rnd; a_in_bypass = byp;
        #1;
        while (!a_in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) chk("a_accept_timeout", 128'(w), 128'd0);
        if (push) qa.push_back('{d: exp_d, e: exp_e});
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [127:0] dat, input logic [3:0] rnd, input logic byp,
                          input logic [127:0] exp_d, input logic exp_e);
        int w = 0;
        b_in_valid = 1'b1; b_in_data = dat; b_in_round = rnd; b_in_bypass = byp;
        #1;
        while (!b_in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) chk("b_accept_timeout", 128'(w), 128'd0);
        qb.push_back('{d: exp_d, e: exp_e});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic a_lat(input string name, input int want);
        int lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk(name, 128'(lat), 128'(want));
    endtask

    task automatic b_lat(input string name, input int want);
        int lat = 0;
        while (!b_out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk(name, 128'(lat), 128'(want));
    endtask

    task automatic drain();
        int w = 0;
        while ((qa.size() != 0 || qb.size() != 0) && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 200) chk("drain_timeout", 128'(qa.size() + qb.size()), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_key_we = 0; a_key_addr = 0; a_key_data = 0; a_in_valid = 0; a_in_data = 0;
        a_in_round = 0; a_in_bypass = 0; a_out_ready = 1;
        b_key_we = 0; b_key_addr = 0; b_key_data = 0; b_in_valid = 0; b_in_data = 0;
        b_in_round = 0; b_in_bypass = 0; b_out_ready = 1;

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("a_ready_in_reset", 128'(a_in_ready), 128'd0);
        rst = 1'b0;
        #1;
        chk("a_ready_after_reset", 128'(a_in_ready), 128'd1);
        chk("a_valid_after_reset", 128'(a_out_valid), 128'd0);
        chk("a_data_after_reset", a_out_data, 128'd0);
        chk("a_err_after_reset", 128'(a_out_err), 128'd0);
        chk("b_ready_after_reset", 128'(b_in_ready), 128'd1);

        // Basic keying, latency 4 with 32-bit lanes
        a_wr(4'd0, K0);
        a_send(D, 4'd0, 1'b0, E0, 1'b0, 1);
        a_lat("a_latency", 4);
        drain();
        a_send(D, 4'd0, 1'b1, D, 1'b0, 1);
        drain();
        a_send(D, 4'd12, 1'b0, D, 1'b1, 1);
        drain();

        // Key overwrite during RUN does not affect the in-flight block
        a_wr(4'd3, K3);
        a_send(D, 4'd3, 1'b0, E3, 1'b0, 1);
        a_wr(4'd3, ONES);
        drain();
        a_send(D, 4'd3, 1'b0, ND, 1'b0, 1);
        drain();

        // Write to the selected slot on the acceptance edge: old key (ONES) is used
        a_key_we = 1'b1; a_key_addr = 4'd3; a_key_data = K3;
        a_send(D, 4'd3, 1'b0, ND, 1'b0, 1);
        a_key_we = 1'b0;
        drain();
        a_send(D, 4'd3, 1'b0, E3, 1'b0, 1);
        drain();
        a_wr(4'd13, ONES);
        a_send(D, 4'd3, 1'b0, E3, 1'b0, 1);
        drain();

        // Backpressure in DONE; a pending in_valid must be ignored
        a_out_ready = 1'b0;
        a_send(D, 4'd0, 1'b0, E0, 1'b0, 1);
        a_lat("a_latency_bp", 4);
        a_in_valid = 1'b1; a_in_data = D2; a_in_round = 4'd0; a_in_bypass = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("a_hold_valid", 128'(a_out_valid), 128'd1);
            chk("a_hold_data", a_out_data, E0);
            chk("a_hold_ready", 128'(a_in_ready), 128'd0);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("a_ready_after_release", 128'(a_in_ready), 128'd1);
        chk("a_valid_after_release", 128'(a_out_valid), 128'd0);
        chk("a_queue_after_release", 128'(qa.size()), 128'd0);

        // Reset in the middle of RUN discards the block and clears keys
        a_send(D2, 4'd0, 1'b0, 128'd0, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("a_ready_after_midrun_reset", 128'(a_in_ready), 128'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("a_no_valid_after_reset", 128'(a_out_valid), 128'd0);
        end
        a_send(D, 4'd0, 1'b0, D, 1'b0, 1);
        drain();
        a_send(D, 4'd3, 1'b0, D, 1'b0, 1);
        drain();

        // Single-beat instance: one-cycle latency
        b_wr(4'd0, K0);
        b_send(D, 4'd0, 1'b0, E0, 1'b0);
        b_lat("b_latency", 1);
        drain();
        b_send(D2, 4'd12, 1'b0, D2, 1'b1);
        b_lat("b_latency_err", 1);
        drain();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        b_send(D, 4'd0, 1'b0, D, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add_round_key_seq.md
Name: add_round_key_seq

Overview:
- Sequential, parametrised AES AddRoundKey engine.
- Holds a bank of NUM_KEYS round keys loaded through a write port.
- Accepts one BLOCK_W-bit state with a round index, XORs it with the selected round key LANE_W bits per cycle, and presents the result on a valid/ready output.
- Sits between the round datapath (SubBytes/ShiftRows/MixColumns) and the key-expansion unit. Lane width trades area against latency.

Parameters:
- BLOCK_W, 128, state and round-key width in bits.
- LANE_W, 32, bits XORed per cycle; must divide BLOCK_W; BEATS = BLOCK_W/LANE_W.
- NUM_KEYS, 11, round-key slots (11 for AES-128, 15 for AES-256).
- KA_W, $clog2(NUM_KEYS), key/round index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- key_we  in  1  write key_data into slot key_addr
- key_addr  in  KA_W  key slot index
- key_data  in  BLOCK_W  round key
- in_valid  in  1  input block valid
- in_ready  out  1  engine can accept a block
- in_data  in  BLOCK_W  state to be keyed
- in_round  in  KA_W  round-key slot to apply
- in_bypass  in  1  pass data unmodified (key forced to 0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  BLOCK_W  in_data XOR round key
- out_err  out  1  in_round was >= NUM_KEYS for this result

Behaviour:
- Lane n = bits [n*LANE_W+LANE_W-1 : n*LANE_W]. Lane 0 is the LSBs, processed first. The result is the concatenation {lane BEATS-1 … lane 0}.
- Reset (synchronous, rst=1 at an edge):
  - state IDLE, beat counter 0
  - in_ready=0 during the reset cycle, 1 from the first cycle after rst drops
  - out_valid=0, out_data=0, out_err=0
  - all key slots cleared to 0
  - an in-flight block is discarded
- FSM:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data into the data register and copy the selected key into the key register. The key is key_mem[in_round], or 0 if in_bypass=1 or in_round>=NUM_KEYS. Latch err = (in_round>=NUM_KEYS)&~in_bypass. Counter=0. Go to RUN.
  - RUN: in_ready=0. Each cycle, data lane[cnt] ^= key lane[cnt] and cnt++. When cnt==BEATS-1 the XOR completes and the FSM goes to DONE.
  - DONE: out_valid=1; out_data and out_err are held stable. On out_ready go to IDLE, and out_valid drops next cycle.
- Latency: acceptance edge T → out_valid high after edge T+BEATS (BEATS=1: the edge after acceptance). Throughput is one block per BEATS+2 cycles with out_ready tied high.
- out_data holds its last value after the handshake; it is only meaningful while out_valid=1.
- Key writes:
  - Allowed in any state, one slot per cycle.
  - key_addr>=NUM_KEYS is ignored.
  - A write does not affect a block already accepted, because the key is copied at acceptance.
  - A write to slot in_round on the acceptance edge uses the old key (read-before-write).
- Backpressure: out_ready low in DONE holds everything indefinitely. in_valid is ignored outside IDLE.
- in_data/in_round/in_bypass are sampled only on the acceptance edge.
- rst asserted in RUN or DONE returns to IDLE next edge and the result is lost.
- XOR is bitwise only; there is no carry.

Test Plan:
- Reset, then load slot 0 = 000102030405060708090a0b0c0d0e0f. Send in_data=00112233445566778899aabbccddeeff, in_round=0. Required: out_data=00102030405060708090a0b0c0d0e0f0, out_err=0, out_valid exactly 4 cycles after the acceptance edge (LANE_W=32).
- Same stimulus with in_bypass=1 → out_data=00112233445566778899aabbccddeeff, out_err=0.
- in_round=12 with NUM_KEYS=11 → out_data=in_data, out_err=1.
- Accept a block on round 3, then overwrite slot 3 with ffff…ff during RUN → result uses the old key. A following block on round 3 uses ffff…ff, giving ~in_data.
- Hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_data stable, in_ready=0. Release → one handshake, then in_ready=1 next cycle.
- Pulse rst during RUN beat 2 → out_valid never asserts, in_ready=1 after reset, all slots read as 0 (a round-0 block returns in_data). Repeat with LANE_W=128 and check 1-cycle latency.
